// File: rtl/frame_update_sched.sv
// Vertical-blanking update scheduler: latches game-logic requests at the start of
// blanking and hands out the update window to one requester at a time, round-robin.
module frame_update_sched #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 4095
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vblnk_in,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             frame_start,
  output logic             commit,
  output logic             busy,
  output logic             overrun,
  output logic             timeout,
  output logic [7:0]       overrun_cnt
);

  localparam int IW = (N_REQ < 2) ? 1 : $clog2(N_REQ);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE      = 1;
  localparam logic [TW-1:0]    TMAX     = TW'(TIMEOUT);
  localparam logic [IW-1:0]    PTR_INIT = IW'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic             vblnk_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             frame_start_q, frame_start_d;
  logic             commit_q, commit_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;

  logic             rise, fall;
  logic [IW-1:0]    cand [N_REQ];
  logic [N_REQ-1:0] cand_hit;
  logic [IW-1:0]    pick_idx;

  assign rise = vblnk_in & ~vblnk_q;
  assign fall = ~vblnk_in & vblnk_q;

  // cand[gi] is the requester at distance gi+1 after the last one served.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum          = {1'b0, ptr_q} + (IW+1)'(gi + 1);
    assign cand[gi]     = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
    assign cand_hit[gi] = pending_q[cand[gi]];
  end

  always_comb begin
    pick_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) pick_idx = cand[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    gnt_d         = gnt_q;
    frame_start_d = 1'b0;
    commit_d      = 1'b0;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    ovr_cnt_d     = ovr_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          pending_d     = req;
          frame_start_d = 1'b1;
          overrun_d     = 1'b0;
          timeout_d     = 1'b0;
          state_d       = S_ARB;
        end
      end
      S_ARB: begin
        if (|pending_q) begin
          gnt_d   = ONE << pick_idx;
          idx_d   = pick_idx;
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          commit_d = vblnk_in & ~overrun_q;
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (done[idx_q] || (timer_q == TMAX)) begin
          gnt_d            = '0;
          pending_d[idx_q] = 1'b0;
          ptr_d            = idx_q;
          state_d          = S_ARB;
          if (!done[idx_q]) timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Blanking ended mid-schedule: flag it, but let the current grant run on.
    if (fall && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      vblnk_q       <= 1'b0;
      pending_q     <= '0;
      ptr_q         <= PTR_INIT;
      idx_q         <= '0;
      timer_q       <= '0;
      gnt_q         <= '0;
      frame_start_q <= 1'b0;
      commit_q      <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      ovr_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      vblnk_q       <= vblnk_in;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      gnt_q         <= gnt_d;
      frame_start_q <= frame_start_d;
      commit_q      <= commit_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      ovr_cnt_q     <= ovr_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign frame_start = frame_start_q;
  assign commit      = commit_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_frame_update_sched.sv
// Scoreboarded bench for frame_update_sched: a frame-level model predicts grant order,
// grant timing, commit and status; a negedge monitor compares the DUT against it.
module tb_frame_update_sched;
  localparam int N  = 3;
  localparam int TO = 15;

  logic         pclk = 1'b0;
  logic         rst = 1'b1;
  logic         vblnk_in = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] gnt;
  logic         frame_start, commit, busy, overrun, timeout;
  logic [7:0]   overrun_cnt;

  frame_update_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .req(req), .done(done),
    .gnt(gnt), .frame_start(frame_start), .commit(commit), .busy(busy),
    .overrun(overrun), .timeout(timeout), .overrun_cnt(overrun_cnt)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int start; logic [N-1:0] oh; int hold; } gexp_t;
  typedef struct { int c; logic ovr; logic to; logic [7:0] cnt; } st_t;
  gexp_t g_q[$];
  int    fs_q[$];
  int    cm_q[$];
  st_t   st_q[$];
  bit    mon_en = 1'b0;

  int m_ptr = N - 1;
  int m_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d, expected none", nm, cyc);
  endtask

  // Monitor: outputs are stable at the falling edge; cyc then names the edge that produced them.
  logic [N-1:0] mon_pgnt  = '0;
  logic         mon_pbusy = 1'b0;
  int           mon_gst   = 0;
  always @(negedge pclk) begin : monitor
    gexp_t ge;
    st_t   se;
    int    ev;
    if (mon_en) begin
      if (frame_start) begin
        if (fs_q.size() == 0) unexp("frame_start");
        else begin ev = fs_q.pop_front(); chk("frame_start_cycle", cyc, ev); end
      end
      if (gnt != mon_pgnt && mon_pgnt != '0) begin
        if (g_q.size() == 0) unexp("grant");
        else begin
          ge = g_q.pop_front();
          chk("gnt_value", mon_pgnt, ge.oh);
          chk("gnt_start", mon_gst, ge.start);
          chk("gnt_hold", cyc - mon_gst, ge.hold);
          $display("[TB] grant %b start %0d hold %0d", mon_pgnt, mon_gst, cyc - mon_gst);
        end
      end
      if (gnt != mon_pgnt && gnt != '0) mon_gst = cyc;
      if (commit) begin
        if (cm_q.size() == 0) unexp("commit");
        else begin ev = cm_q.pop_front(); chk("commit_cycle", cyc, ev); end
      end
      if (mon_pbusy && !busy) begin
        if (st_q.size() == 0) unexp("busy_fall");
        else begin
          se = st_q.pop_front();
          chk("busy_fall_cycle", cyc, se.c);
          chk("overrun", overrun, se.ovr);
          chk("timeout", timeout, se.to);
          chk("overrun_cnt", overrun_cnt, se.cnt);
          $display("[TB] frame end cycle %0d overrun %0b timeout %0b cnt %0d",
                   cyc, overrun, timeout, overrun_cnt);
        end
      end
    end
    mon_pgnt  = gnt;
    mon_pbusy = busy;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_commit"}, commit, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_overrun_cnt"}, overrun_cnt, 0);
  endtask

  // One blanking frame. dN = cycles from grant to done (0 = never answers).
  // Called just after a falling edge; returns just after a falling edge with vblnk low.
  task automatic run_frame(input logic [N-1:0] rq, input int d0, input int d1, input int d2,
                           input int blank_len, input bit extra, input bit noise, input bit stray);
    int dly[N];
    int e0, k, f, g, c, r, rr, hold, f2a, f2b, nfall, end_t, gst, gidx, age;
    bit any_to, ovr, use_extra, vh;
    logic [N-1:0] pend, oh, dn, dprev;
    gexp_t ge;
    st_t   se;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    e0 = cyc; k = e0 + 1; f = k + blank_len;
    pend = rq; g = k + 1; any_to = 1'b0;
    while (pend != '0) begin
      r = -1;
      for (int off = 1; off <= N; off++) begin
        rr = (m_ptr + off) % N;
        if (r < 0 && pend[rr]) r = rr;
      end
      hold = (dly[r] == 0) ? TO + 1 : dly[r];
      oh = '0; oh[r] = 1'b1;
      ge.start = g; ge.oh = oh; ge.hold = hold;
      g_q.push_back(ge);
      if (dly[r] == 0) any_to = 1'b1;
      m_ptr = r; pend[r] = 1'b0;
      g = g + hold + 1;
    end
    c = g;
    fs_q.push_back(k);
    ovr = (f <= c);
    if (!ovr) cm_q.push_back(c);
    f2a = f + 2; f2b = f + 4;
    use_extra = extra && (f2b <= c);
    nfall = (ovr ? 1 : 0) + (use_extra ? 1 : 0);
    m_cnt = (m_cnt + nfall > 255) ? 255 : m_cnt + nfall;
    se.c = c; se.ovr = ovr; se.to = any_to; se.cnt = 8'(m_cnt);
    st_q.push_back(se);

    vblnk_in = 1'b1; req = rq; done = '0;
    end_t = ((use_extra ? f2b : f) > c ? (use_extra ? f2b : f) : c) + 3;
    dprev = '0; gst = 0;
    for (int t = e0 + 1; t <= end_t; t++) begin
      @(negedge pclk);
      vh = ((t + 1) >= k && (t + 1) < f) || (use_extra && (t + 1) >= f2a && (t + 1) < f2b);
      vblnk_in = vh;
      req = N'($urandom);
      dn = '0;
      if (gnt != '0) begin
        if (gnt != dprev) gst = t;
        gidx = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) gidx = i;
        age = t - gst;
        if (dly[gidx] != 0 && age == dly[gidx] - 1) dn[gidx] = 1'b1;
      end
      dprev = gnt;
      if (noise) dn = dn | (N'($urandom) & ~gnt);
      if (stray && t >= k && t <= k + 3) dn = '1;
      done = dn;
    end
    done = '0; req = '0; vblnk_in = 1'b0;
    chk("fs_queue_left", fs_q.size(), 0);
    chk("gnt_queue_left", g_q.size(), 0);
    chk("commit_queue_left", cm_q.size(), 0);
    chk("status_queue_left", st_q.size(), 0);
  endtask

  initial begin : driver
    int n010;
    logic [N-1:0] rq;
    int rd [N];
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    chk_reset("por");
    @(negedge pclk);

    // Reset in the middle of a grant held by requester 1.
    vblnk_in = 1'b1; req = '1; n010 = 0;
    for (int i = 0; i < 60 && n010 < 4; i++) begin
      @(negedge pclk);
      done = (gnt == 3'b001) ? 3'b001 : 3'b000;
      if (gnt == 3'b010) n010++;
    end
    chk("midwait_reached", n010, 4);
    done = '0; rst = 1'b1;
    @(negedge pclk);
    chk_reset("midwait_rst");
    rst = 1'b0; vblnk_in = 1'b0; req = '0;
    repeat (2) @(negedge pclk);
    m_ptr = N - 1; m_cnt = 0;
    mon_en = 1'b1;
    @(negedge pclk);

    run_frame(3'b111, 5, 5, 5, 100, 0, 0, 0);   // in-order grants after reset
    run_frame(3'b011, 3, 3, 3, 100, 0, 1, 0);   // round-robin carry-over
    run_frame(3'b111, 4, 4, 4, 100, 0, 1, 0);
    run_frame(3'b001, 2, 2, 2, 50, 0, 0, 0);
    run_frame(3'b111, 3, 0, 3, 100, 0, 1, 0);   // requester 1 times out
    run_frame(3'b111, 10, 10, 10, 20, 0, 0, 0); // overrun
    run_frame(3'b101, 2, 2, 2, 60, 0, 0, 0);    // overrun cleared
    run_frame(3'b111, 10, 10, 10, 20, 1, 0, 0); // re-rise while busy is ignored
    run_frame(3'b000, 1, 1, 1, 30, 0, 0, 1);    // empty frame, stray done
    for (int n = 0; n < 30; n++) begin
      rq = N'($urandom);
      for (int i = 0; i < N; i++) rd[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      run_frame(rq, rd[0], rd[1], rd[2], int'($urandom_range(3, 80)),
                1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    repeat (3) @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
